// File: rtl/ring_counter_param.sv
// rtl/ring_counter_param.sv - parametrised ring/Johnson shift sequencer
//
// Purpose: shift-ring sequencer for phase selects and round-robin slot strobes.
//   Runtime selectable one-hot ring or Johnson (twisted ring), either direction,
//   with enable, parallel load, illegal-state self-correction and status pulses.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (0 = reset)
//   en       advance one step per clock
//   dir      0 = shift toward MSB, 1 = shift toward LSB
//   mode     0 = one-hot ring, 1 = Johnson
//   load     synchronous parallel load of load_val
//   load_val value to load
//   q        counter state (registered)
//   wrap     1-cycle pulse: a shift has just returned q to the mode seed
//   err      1-cycle pulse: an illegal state or load was corrected to seed

module ring_counter_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  logic             mode_q;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             err_next;
  logic             load_ok;
  logic             q_ok;

  // Ring: exactly one bit set. Johnson: at most one adjacent bit boundary,
  // which covers all-zeros, all-ones, 0..01..1 and 1..10..0.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    int ones;
    int flips;
    ones  = 0;
    flips = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(v[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      flips = flips + int'(v[i] ^ v[i+1]);
    end
    if (m) begin
      is_legal = (flips <= 1);
    end else begin
      is_legal = (ones == 1);
    end
  endfunction

  always_comb begin
    // Ring seed is LSB-only, Johnson seed is all zeros.
    seed    = '0;
    seed[0] = ~mode;

    // XOR with mode inverts the bit fed back in Johnson mode only.
    if (dir) begin
      shifted = {q[0] ^ mode, q[WIDTH-1:1]};
    end else begin
      shifted = {q[WIDTH-2:0], q[WIDTH-1] ^ mode};
    end

    load_ok = is_legal(load_val, mode);
    q_ok    = is_legal(q, mode);

    q_next    = q;
    wrap_next = 1'b0;
    err_next  = 1'b0;

    if (load) begin
      // A mode change in the same cycle is absorbed: legality is judged
      // against the incoming mode, and mode_q follows it below.
      if (load_ok) begin
        q_next = load_val;
      end else begin
        q_next   = seed;
        err_next = 1'b1;
      end
    end else if (mode != mode_q) begin
      q_next = seed;
    end else if (en && !q_ok) begin
      q_next   = seed;
      err_next = 1'b1;
    end else if (en) begin
      q_next    = shifted;
      wrap_next = (shifted == seed);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= WIDTH'(1);
      wrap   <= 1'b0;
      err    <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      q      <= q_next;
      wrap   <= wrap_next;
      err    <= err_next;
      mode_q <= mode;
    end
  end

endmodule
